// File: rtl/mux41_rr_arbiter_pkg.sv
// Shared types and constants for the 4-way round-robin arbiter that owns a mux41 select.
package mux41_arb_pkg;
    localparam int NUM_REQ = 4;
    localparam int SEL_W   = 2;

    typedef enum logic {
        IDLE,
        GRANT
    } arb_state_e;

    function automatic logic [NUM_REQ-1:0] onehot4(input logic [SEL_W-1:0] s);
        return NUM_REQ'(1) << s;
    endfunction
endpackage

// File: rtl/mux41_rr_arbiter_if.sv
// Request/grant bus between four requesters and the arbiter; slave is the arbiter side.
interface mux41_rr_arbiter_if;
    import mux41_arb_pkg::*;

    logic [NUM_REQ-1:0] req;
    logic [NUM_REQ-1:0] gnt;
    logic [SEL_W-1:0]   sel;
    logic               sel_valid;

    modport master (output req, input gnt, sel, sel_valid);
    modport slave  (input req, output gnt, sel, sel_valid);
endinterface

// File: rtl/mux41_rr_arbiter_pick.sv
// Rotated priority scan over four requests: first set bit at last+1, last+2, last+3, last.
module rr_pick4
    import mux41_arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [SEL_W-1:0]   last,
    output logic [SEL_W-1:0]   pick,
    output logic               any
);
    always_comb begin
        pick = last;
        any  = |req;
        // Walk from the farthest slot back toward last+1 so the nearest hit wins.
        for (int k = NUM_REQ; k >= 1; k--) begin
            if (req[last + SEL_W'(k)]) begin
                pick = last + SEL_W'(k);
            end
        end
    end
endmodule

// File: rtl/mux41_rr_arbiter.sv
// Round-robin arbiter sharing one 4:1 mux; break-before-make with a bounded hold time.
module mux41_rr_arbiter
    import mux41_arb_pkg::*;
#(
    parameter int HOLD_MAX = 8
)(
    input  logic              clk,
    input  logic              rst,
    mux41_rr_arbiter_if.slave bus
);
    localparam int CNT_W = $clog2(HOLD_MAX) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD_MAX - 1);

    if (HOLD_MAX < 1) begin : g_bad_hold
        $error("mux41_rr_arbiter: HOLD_MAX must be >= 1");
    end

    arb_state_e       state;
    logic [CNT_W-1:0] cnt;
    logic [SEL_W-1:0] last;
    logic [SEL_W-1:0] pick;
    logic             any;
    logic             release_now;

    rr_pick4 u_pick (
        .req  (bus.req),
        .last (last),
        .pick (pick),
        .any  (any)
    );

    // sel always names the current owner while in GRANT.
    assign release_now = !bus.req[bus.sel] || (cnt == CNT_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            bus.gnt       <= '0;
            bus.sel       <= '0;
            bus.sel_valid <= 1'b0;
            cnt           <= '0;
            last          <= SEL_W'(NUM_REQ - 1);
        end else begin
            case (state)
                IDLE: begin
                    if (any) begin
                        state         <= GRANT;
                        bus.gnt       <= onehot4(pick);
                        bus.sel       <= pick;
                        bus.sel_valid <= 1'b1;
                        cnt           <= '0;
                    end
                end
                GRANT: begin
                    if (release_now) begin
                        // sel is left untouched so the mux select never moves with valid high.
                        state         <= IDLE;
                        bus.gnt       <= '0;
                        bus.sel_valid <= 1'b0;
                        last          <= bus.sel;
                        cnt           <= '0;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state         <= IDLE;
                    bus.gnt       <= '0;
                    bus.sel_valid <= 1'b0;
                end
            endcase
        end
    end
endmodule
